// File: rtl/lzc_pkg.sv
// Shared definitions for the leading/trailing-zero count + normalise pipeline.
//   LZC_MODE_LEAD / LZC_MODE_TRAIL : values of in_mode
//   lzc_cnt_w(width)               : count width able to hold the value `width`
package lzc_pkg;

  localparam logic LZC_MODE_LEAD  = 1'b0;
  localparam logic LZC_MODE_TRAIL = 1'b1;

  function automatic int lzc_cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/lzc_norm_pipe_if.sv
// Operand/result bus of lzc_norm_pipe.
//   in_*  : operand channel (valid/ready), data, mode, sideband tag
//   out_* : result channel (valid/ready), count, normalised operand, zero flag, tag
//   master: producer/consumer side, slave: the pipeline
interface lzc_norm_pipe_if
  import lzc_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4
) ();

  localparam int CNT_W = lzc_cnt_w(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_mode;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_count;
  logic [WIDTH-1:0] out_norm;
  logic             out_zero;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_data, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_count, out_norm, out_zero, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_count, out_norm, out_zero, out_tag
  );

endinterface

// File: rtl/lzc_tree.sv
// Combinational leading-zero counter built as a recursive priority tree.
//   d_i    : operand (W bits, W a power of two)
//   cnt_o  : zeros from the MSB down to the first one; W when d_i == 0
//   zero_o : d_i is all zeros
module lzc_tree #(
  parameter int W = 64
) (
  input  logic [W-1:0]     d_i,
  output logic [$clog2(W):0] cnt_o,
  output logic             zero_o
);

  localparam int CW = $clog2(W) + 1;

  if (W == 1) begin : g_leaf
    assign cnt_o  = ~d_i;
    assign zero_o = ~d_i[0];
  end else begin : g_node
    logic [CW-2:0] hi_cnt, lo_cnt;
    logic          hi_zero, lo_zero;

    lzc_tree #(.W(W/2)) u_hi (.d_i(d_i[W-1:W/2]), .cnt_o(hi_cnt), .zero_o(hi_zero));
    lzc_tree #(.W(W/2)) u_lo (.d_i(d_i[W/2-1:0]), .cnt_o(lo_cnt), .zero_o(lo_zero));

    // An all-zero low half reports W/2, so the sum lands on W for a zero operand.
    assign cnt_o  = hi_zero ? (CW'(W/2) + {1'b0, lo_cnt}) : {1'b0, hi_cnt};
    assign zero_o = hi_zero & lo_zero;
  end

endmodule

// File: rtl/lzc_norm_pipe.sv
// Two-stage pipelined leading/trailing-zero counter with normaliser.
//   clk, rst : clock, synchronous active-high reset
//   bus      : lzc_norm_pipe_if slave (operand in, result out, valid/ready each)
// Stage 1 registers count/zero/data/mode/tag; stage 2 registers the shifted
// operand. Latency 2, throughput 1/cycle.
module lzc_norm_pipe
  import lzc_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4
) (
  input logic           clk,
  input logic           rst,
  lzc_norm_pipe_if.slave bus
);

  localparam int CNT_W = lzc_cnt_w(WIDTH);

  // Stage 0: trailing mode bit-reverses so one leading-zero tree serves both.
  logic [WIDTH-1:0] s0_opnd;
  logic [CNT_W-1:0] s0_cnt;
  logic             s0_zero;

  always_comb begin
    s0_opnd = bus.in_data;
    if (bus.in_mode == LZC_MODE_TRAIL)
      for (int i = 0; i < WIDTH; i++) s0_opnd[i] = bus.in_data[WIDTH-1-i];
  end

  lzc_tree #(.W(WIDTH)) u_tree (.d_i(s0_opnd), .cnt_o(s0_cnt), .zero_o(s0_zero));

  // Stage 1 state
  logic             s1_valid_q;
  logic [CNT_W-1:0] s1_cnt_q;
  logic             s1_zero_q;
  logic [WIDTH-1:0] s1_data_q;
  logic             s1_mode_q;
  logic [TAG_W-1:0] s1_tag_q;

  // Stage 2 (output) state
  logic             s2_valid_q;
  logic [CNT_W-1:0] s2_cnt_q;
  logic             s2_zero_q;
  logic [WIDTH-1:0] s2_norm_q, s2_norm_d;
  logic [TAG_W-1:0] s2_tag_q;

  logic s2_adv, s1_adv;

  assign s2_adv = !s2_valid_q || bus.out_ready;
  assign s1_adv = s1_valid_q && s2_adv;
  assign bus.in_ready = !s1_valid_q || s1_adv;

  // Shift by WIDTH (zero operand) yields 0, which is the required norm.
  assign s2_norm_d = (s1_mode_q == LZC_MODE_TRAIL) ? (s1_data_q >> s1_cnt_q)
                                                   : (s1_data_q << s1_cnt_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_cnt_q   <= '0;
      s1_zero_q  <= 1'b0;
      s1_data_q  <= '0;
      s1_mode_q  <= 1'b0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_cnt_q   <= '0;
      s2_zero_q  <= 1'b0;
      s2_norm_q  <= '0;
      s2_tag_q   <= '0;
    end else begin
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_cnt_q  <= s1_cnt_q;
          s2_zero_q <= s1_zero_q;
          s2_norm_q <= s2_norm_d;
          s2_tag_q  <= s1_tag_q;
        end
      end
      if (bus.in_ready) begin
        s1_valid_q <= bus.in_valid;
        if (bus.in_valid) begin
          s1_cnt_q  <= s0_cnt;
          s1_zero_q <= s0_zero;
          s1_data_q <= bus.in_data;
          s1_mode_q <= bus.in_mode;
          s1_tag_q  <= bus.in_tag;
        end
      end
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.out_count = s2_cnt_q;
  assign bus.out_norm  = s2_norm_q;
  assign bus.out_zero  = s2_zero_q;
  assign bus.out_tag   = s2_tag_q;

endmodule

// File: tb/tb_lzc_norm_pipe.sv
// Scoreboard bench for lzc_norm_pipe (WIDTH=64): driver pushes expected
// results on accept, a monitor pops and compares on every output transfer.
module tb_lzc_norm_pipe;
  import lzc_pkg::*;

  localparam int W  = 64;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lzc_norm_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus ();
  lzc_norm_pipe #(.WIDTH(W), .TAG_W(TW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int          cnt;
    logic [63:0] norm;
    logic        zero;
    logic [3:0]  tag;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   lat_chk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int c, input logic [63:0] n, input logic z);
    exp_t e;
    e.cnt = c; e.norm = n; e.zero = z; e.tag = '0; e.acc = 0; e.lat = 1'b0;
    return e;
  endfunction

  // Reference: walk bits from the chosen end until the first one.
  function automatic exp_t model(input logic [63:0] d, input bit m);
    int n = 0;
    logic [63:0] nm;
    if (!m) while (n < 64 && d[63-n] == 1'b0) n++;
    else    while (n < 64 && d[n] == 1'b0) n++;
    if (d == 64'd0) nm = 64'd0;
    else nm = m ? (d >> n) : (d << n);
    return mk(n, nm, d == 64'd0);
  endfunction

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_result: got tag %0h, expected no result", bus.out_tag);
        end else begin
          e = q.pop_front();
          chk("count", bus.out_count, e.cnt);
          chk("norm",  bus.out_norm,  e.norm);
          chk("zero",  bus.out_zero,  e.zero);
          chk("tag",   bus.out_tag,   e.tag);
          if (e.lat) chk("latency", cyc, e.acc + 2);
        end
      end
    end
  end

  task automatic send(input logic [63:0] d, input bit m, input logic [3:0] t, input exp_t e);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_mode  = m;
    bus.in_tag   = t;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        e.tag = t; e.acc = cyc; e.lat = lat_chk;
        q.push_back(e);
      end
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 for 50 cycles, expected 1");
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [63:0] d, input bit m, input logic [3:0] t);
    send(d, m, t, model(d, m));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  logic [63:0] bp_d [5];
  bit          bp_m [5];
  exp_t        bp0;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_mode   = 1'b0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_count", bus.out_count, 0);
    chk("rst_out_norm",  bus.out_norm,  0);
    chk("rst_out_zero",  bus.out_zero,  0);
    chk("rst_out_tag",   bus.out_tag,   0);
    chk("rst_in_ready",  bus.in_ready,  1);
    @(posedge clk); #1;

    // Directed cases with hand-derived expectations
    lat_chk = 1'b1;
    send(64'h0000_0000_0000_0001, LZC_MODE_LEAD,  4'd3, mk(63, 64'h8000_0000_0000_0000, 1'b0));
    send(64'h0000_0100_0000_0000, LZC_MODE_TRAIL, 4'd5, mk(40, 64'h0000_0000_0000_0001, 1'b0));
    send(64'h0,                   LZC_MODE_LEAD,  4'd6, mk(64, 64'h0, 1'b1));
    send(64'h0,                   LZC_MODE_TRAIL, 4'd7, mk(64, 64'h0, 1'b1));
    send(64'h8000_0000_0000_0000, LZC_MODE_TRAIL, 4'd8, mk(63, 64'h1, 1'b0));
    send(64'hFFFF_FFFF_FFFF_FFFF, LZC_MODE_LEAD,  4'd9, mk(0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0));
    idle(4);

    // Back-pressure: 5 ops streamed while out_ready held low
    lat_chk = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bp_d[i] = ({$urandom, $urandom} >> $urandom_range(0, 40)) | 64'h1;
      bp_m[i] = 1'($urandom_range(0, 1));
    end
    bp0 = model(bp_d[0], bp_m[0]);
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) send_m(bp_d[i], bp_m[i], 4'(i + 1));
      end
      begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_full", bus.in_ready, 0);
        chk("bp_out_valid", bus.out_valid, 1);
        repeat (2) begin
          @(negedge clk);
          chk("bp_hold_tag",   bus.out_tag,   1);
          chk("bp_hold_count", bus.out_count, bp0.cnt);
          chk("bp_hold_norm",  bus.out_norm,  bp0.norm);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    idle(6);

    // Full throughput, random operands
    lat_chk = 1'b1;
    for (int i = 0; i < 100; i++) begin
      logic [63:0] d;
      d = ({$urandom, $urandom} >> $urandom_range(0, 63)) << $urandom_range(0, 63);
      if ($urandom_range(0, 15) == 0) d = 64'd0;
      send_m(d, 1'($urandom_range(0, 1)), 4'($urandom));
    end
    idle(4);

    // Reset with two ops in flight
    lat_chk = 1'b0;
    bus.out_ready = 1'b0;
    send_m(64'h0000_0000_00F0_0000, LZC_MODE_LEAD,  4'hA);
    send_m(64'h0F00_0000_0000_0000, LZC_MODE_TRAIL, 4'hB);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    @(negedge clk);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready",  bus.in_ready,  1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    lat_chk = 1'b1;
    send(64'h0000_0000_0001_0000, LZC_MODE_LEAD, 4'hC, mk(47, 64'h8000_0000_0000_0000, 1'b0));
    idle(6);

    chk("all_results_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
